imem_access_arbiter: RTL

IMEM_ACCESS_ARBITER -- requirements
Module: imem_access_arbiter

---
 rtl/imem_access_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_access_arbiter.sv
// -----------------------------------------------------------------------------
// imem_access_arbiter
//
// Shares one instruction-memory port between the core's fetch path and a
// boot/patch loader.
//   BOOT  : the loader owns the port and the core is stalled. ld_done moves
//           the block to RUN; a write in that same cycle still completes.
//   RUN   : the core fetches. A pending loader write is noted and the block
//           moves to PATCH on the next edge, so the current cycle is still a
//           fetch.
//   PATCH : the loader owns the port for at most BURST_MAX accepted writes.
//           The block then returns to RUN for at least one fetch cycle, so
//           the core is never starved.
//
// Ports
//   clk, rst     : clock; synchronous active-high reset
//   pc           : core fetch byte address
//   fetch_req    : core wants an instruction this cycle
//   fetch_grant  : mem_addr carries pc this cycle and the read data is valid
//   stall        : core must hold pc
//   ld_valid     : loader write request
//   ld_ready     : loader write accepted when ld_valid & ld_ready
//   ld_addr      : loader byte address
//   ld_data      : loader write word
//   ld_done      : boot image complete (only looked at in BOOT)
//   mem_addr     : word index to instruction memory
//   mem_we       : memory write enable
//   mem_wdata    : memory write data
//   core_run     : high in every state except BOOT
//   ld_count     : accepted loader writes since reset, saturating at 2047
//   addr_err     : sticky flag for a misaligned or out-of-range access
// -----------------------------------------------------------------------------
module imem_access_arbiter #(
  parameter int DEPTH     = 1024,
  parameter int BURST_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        fetch_req,
  output logic        fetch_grant,
  output logic        stall,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        ld_done,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        core_run,
  output logic [10:0] ld_count,
  output logic        addr_err
);

  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    PATCH = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [BW-1:0]   burst_cnt, burst_next;
  logic            ld_err, pc_err;
  logic            accept, err_hit;

  // Misaligned, above the 4 KiB window, or beyond the configured depth.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:12] != 20'd0) ||
           (32'(a[11:2]) >= 32'(DEPTH));
  endfunction

  assign ld_err    = addr_bad(ld_addr);
  assign pc_err    = addr_bad(pc);
  assign mem_wdata = ld_data;
  assign core_run  = (state != BOOT);

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    burst_next  = '0;
    fetch_grant = 1'b0;
    stall       = 1'b1;
    ld_ready    = 1'b1;
    mem_addr    = ld_addr[11:2];
    // An erroring loader write is still accepted, it just never reaches memory.
    mem_we      = ld_valid & ~ld_err;

    case (state)
      BOOT: begin
        if (ld_done) state_next = RUN;
      end

      RUN: begin
        stall       = 1'b0;
        ld_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = pc[11:2];
        fetch_grant = fetch_req;
        if (ld_valid) state_next = PATCH;
      end

      PATCH: begin
        if (!ld_valid) begin
          state_next = RUN;
        end else if (burst_cnt == BW'(BURST_MAX - 1)) begin
          // This write is the last of the burst; hand one cycle back to the core.
          state_next = RUN;
        end else begin
          burst_next = burst_cnt + 1'b1;
        end
      end

      default: state_next = BOOT;
    endcase
  end

  assign accept  = ld_valid & ld_ready;
  assign err_hit = (accept & ld_err) | (fetch_grant & pc_err);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      burst_cnt <= '0;
      ld_count  <= '0;
      addr_err  <= 1'b0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
      if (accept && ld_count != 11'h7FF) ld_count <= ld_count + 11'd1;
      if (err_hit) addr_err <= 1'b1;
    end
  end

endmodule
